// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// loader FSM states, default geometry and the end-of-program word.
package instr_loader_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BYTE_WIDTH_DEF = 8;
    localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;
    localparam int MEM_DEPTH_DEF  = 256;
    localparam int ADDR_INCR_DEF  = 1;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs a byte stream MSB-first into words; word_ready pulses combinationally
// with the last byte so the caller can latch 'word' on that same edge.
module instr_loader_word_assembler
    import instr_loader_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int BYTES      = BYTES_PER_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          rx_valid,
    input  logic [BYTE_WIDTH-1:0]         rx_data,
    output logic [BYTES*BYTE_WIDTH-1:0]   word,
    output logic                          word_ready
);

    localparam int CW = $clog2(BYTES);
    localparam int SW = (BYTES - 1) * BYTE_WIDTH;

    logic [SW-1:0] shift_r;
    logic [CW-1:0] count_r;
    logic          take_s;
    logic          last_s;

    assign take_s     = enable & rx_valid;
    assign last_s     = (count_r == CW'(BYTES - 1));
    assign word       = {shift_r, rx_data};
    assign word_ready = take_s & last_s;

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_r <= {SW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (take_s) begin
            shift_r <= word[SW-1:0];
            count_r <= last_s ? {CW{1'b0}} : count_r + CW'(1);
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: assembles UART bytes into instructions and writes them to
// instruction memory until the HALT word is seen or the memory is full.
module instr_loader #(
    parameter int                    DATA_WIDTH = instr_loader_pkg::DATA_WIDTH_DEF,
    parameter int                    BYTE_WIDTH = instr_loader_pkg::BYTE_WIDTH_DEF,
    parameter int                    MEM_DEPTH  = instr_loader_pkg::MEM_DEPTH_DEF,
    parameter int                    ADDR_INCR  = instr_loader_pkg::ADDR_INCR_DEF,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = instr_loader_pkg::HALT_WORD
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_write,
    output logic                  o_done,
    output logic                  o_overflow
);

    import instr_loader_pkg::*;

    state_e                state_r;
    state_e                next_state_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  word_ready_s;
    logic                  session_start_s;
    logic                  accept_s;
    logic                  last_addr_s;
    logic                  halt_s;
    logic [DATA_WIDTH-1:0] instr_nxt_s;
    logic [DATA_WIDTH-1:0] addr_nxt_s;
    logic                  write_nxt_s;
    logic                  loading_nxt_s;
    logic                  done_nxt_s;
    logic                  overflow_nxt_s;

    assign session_start_s = i_start & ((state_r == IDLE) | (state_r == DONE));
    // A byte arriving during the WRITE cycle already belongs to the next word.
    assign accept_s        = (state_r == RECEIVE) | (state_r == WRITE);
    assign last_addr_s     = (o_address == DATA_WIDTH'(MEM_DEPTH - 1));
    assign halt_s          = (o_instruccion == HALT_WORD);

    instr_loader_word_assembler #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .BYTES      (DATA_WIDTH / BYTE_WIDTH)
    ) u_word_assembler (
        .clk        (i_clock),
        .rst_n      (i_reset),
        .clear      (session_start_s),
        .enable     (accept_s),
        .rx_valid   (i_rx_valid),
        .rx_data    (i_rx_data),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (session_start_s) next_state_s = RECEIVE;
                else                 next_state_s = state_r;
            end
            RECEIVE: begin
                if (word_ready_s) next_state_s = WRITE;
                else              next_state_s = RECEIVE;
            end
            WRITE: begin
                if (halt_s || last_addr_s) next_state_s = DONE;
                else                       next_state_s = RECEIVE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with next_state_s.
    always_comb begin
        instr_nxt_s    = o_instruccion;
        addr_nxt_s     = o_address;
        overflow_nxt_s = o_overflow;
        write_nxt_s    = (next_state_s == WRITE);
        loading_nxt_s  = (next_state_s == RECEIVE) | (next_state_s == WRITE);
        done_nxt_s     = (next_state_s == DONE);
        case (state_r)
            IDLE, DONE: begin
                if (session_start_s) begin
                    addr_nxt_s     = {DATA_WIDTH{1'b0}};
                    overflow_nxt_s = 1'b0;
                end else begin
                    addr_nxt_s     = o_address;
                end
            end
            RECEIVE: begin
                if (word_ready_s) instr_nxt_s = word_s;
                else              instr_nxt_s = o_instruccion;
            end
            WRITE: begin
                if (halt_s)           addr_nxt_s     = o_address;
                else if (last_addr_s) overflow_nxt_s = 1'b1;
                else                  addr_nxt_s     = o_address + DATA_WIDTH'(ADDR_INCR);
            end
            default: begin
                addr_nxt_s = o_address;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_instruccion <= {DATA_WIDTH{1'b0}};
            o_address     <= {DATA_WIDTH{1'b0}};
            o_loading     <= 1'b0;
            o_write       <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_instruccion <= instr_nxt_s;
            o_address     <= addr_nxt_s;
            o_loading     <= loading_nxt_s;
            o_write       <= write_nxt_s;
            o_done        <= done_nxt_s;
            o_overflow    <= overflow_nxt_s;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (MEM_DEPTH=4): vector table for the main
// load/overflow flow, hand sequences for reset mid-word and restart cases.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        loading;
    logic        wr;
    logic        done;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_loader #(
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .MEM_DEPTH  (4),
        .ADDR_INCR  (1),
        .HALT_WORD  (32'hFC00_0000)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_instruccion (instr),
        .o_address     (addr),
        .o_loading     (loading),
        .o_write       (wr),
        .o_done        (done),
        .o_overflow    (ovf)
    );

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        w;
        logic        l;
        logic        dn;
        logic        ov;
        logic        ci;
        logic [31:0] ins;
        logic [31:0] a;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic w, input logic l, input logic dn, input logic ov,
                       input logic ci, input logic [31:0] ins, input logic [31:0] a);
        vec_t t;
        t = '{s, v, d, w, l, dn, ov, ci, ins, a};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic check_out(input string tag, input logic w, input logic l,
                             input logic dn, input logic ov, input logic ci,
                             input logic [31:0] ins, input logic [31:0] a);
        chk({tag, " write"},    {31'd0, wr},      {31'd0, w});
        chk({tag, " loading"},  {31'd0, loading}, {31'd0, l});
        chk({tag, " done"},     {31'd0, done},    {31'd0, dn});
        chk({tag, " overflow"}, {31'd0, ovf},     {31'd0, ov});
        chk({tag, " address"},  addr, a);
        if (ci) chk({tag, " instr"}, instr, ins);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b0, 1'b1, b);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hFF);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int wcount;

        // Basic load: two words, second is HALT.
        add(1, 0, 8'h00, 0, 1, 0, 0, 1, 32'h0000_0000, 0);  // start
        add(0, 1, 8'h20, 0, 1, 0, 0, 1, 32'h0000_0000, 0);
        add(0, 1, 8'h01, 0, 1, 0, 0, 1, 32'h0000_0000, 0);
        add(0, 1, 8'h00, 0, 1, 0, 0, 1, 32'h0000_0000, 0);
        add(0, 1, 8'h05, 1, 1, 0, 0, 1, 32'h2001_0005, 0);  // 4th byte -> write next cycle
        add(0, 0, 8'h00, 0, 1, 0, 0, 1, 32'h2001_0005, 1);
        add(0, 1, 8'hFC, 0, 1, 0, 0, 1, 32'h2001_0005, 1);
        add(0, 1, 8'h00, 0, 1, 0, 0, 1, 32'h2001_0005, 1);
        add(0, 1, 8'h00, 0, 1, 0, 0, 1, 32'h2001_0005, 1);
        add(0, 1, 8'h00, 1, 1, 0, 0, 1, 32'hFC00_0000, 1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 1, 32'hFC00_0000, 1);  // DONE, no overflow
        add(0, 1, 8'hAB, 0, 0, 1, 0, 1, 32'hFC00_0000, 1);  // byte ignored
        // Restart, back-to-back words, then fill memory to overflow.
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 32'h0000_0000, 0);
        add(0, 1, 8'h11, 0, 1, 0, 0, 0, 32'h0000_0000, 0);
        add(0, 1, 8'h22, 0, 1, 0, 0, 0, 32'h0000_0000, 0);
        add(0, 1, 8'h33, 0, 1, 0, 0, 0, 32'h0000_0000, 0);
        add(0, 1, 8'h44, 1, 1, 0, 0, 1, 32'h1122_3344, 0);
        add(0, 1, 8'h55, 0, 1, 0, 0, 1, 32'h1122_3344, 1);  // byte in WRITE cycle
        add(0, 1, 8'h66, 0, 1, 0, 0, 1, 32'h1122_3344, 1);
        add(0, 1, 8'h77, 0, 1, 0, 0, 1, 32'h1122_3344, 1);
        add(0, 1, 8'h88, 1, 1, 0, 0, 1, 32'h5566_7788, 1);
        add(0, 1, 8'h01, 0, 1, 0, 0, 1, 32'h5566_7788, 2);
        add(0, 1, 8'h02, 0, 1, 0, 0, 1, 32'h5566_7788, 2);
        add(0, 1, 8'h03, 0, 1, 0, 0, 1, 32'h5566_7788, 2);
        add(0, 1, 8'h04, 1, 1, 0, 0, 1, 32'h0102_0304, 2);
        add(0, 0, 8'h00, 0, 1, 0, 0, 1, 32'h0102_0304, 3);
        add(0, 1, 8'h05, 0, 1, 0, 0, 1, 32'h0102_0304, 3);
        add(0, 1, 8'h06, 0, 1, 0, 0, 1, 32'h0102_0304, 3);
        add(0, 1, 8'h07, 0, 1, 0, 0, 1, 32'h0102_0304, 3);
        add(0, 1, 8'h08, 1, 1, 0, 0, 1, 32'h0506_0708, 3);  // last legal address
        add(0, 0, 8'h00, 0, 0, 1, 1, 1, 32'h0506_0708, 3);  // overflow
        add(0, 1, 8'h09, 0, 0, 1, 1, 1, 32'h0506_0708, 3);
        add(0, 1, 8'h0A, 0, 0, 1, 1, 1, 32'h0506_0708, 3);
        add(0, 1, 8'h0B, 0, 0, 1, 1, 1, 32'h0506_0708, 3);
        add(0, 1, 8'h0C, 0, 0, 1, 1, 1, 32'h0506_0708, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 1, 32'h0506_0708, 3);

        // Reset with busy inputs, then bytes in IDLE must be ignored.
        do_reset();
        check_out("reset", 0, 0, 0, 0, 1, 32'h0, 32'h0);
        send(8'h12);
        send(8'h34);
        idle();
        check_out("idle_bytes", 0, 0, 0, 0, 1, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].v, vecs[i].d);
            tick();
            check_out($sformatf("v%0d", i), vecs[i].w, vecs[i].l, vecs[i].dn,
                      vecs[i].ov, vecs[i].ci, vecs[i].ins, vecs[i].a);
        end
        idle();

        // Reset mid-word: partial word discarded, single clean write afterwards.
        drive(1'b1, 1'b0, 8'h00);
        tick();
        send(8'h01);
        send(8'h02);
        do_reset();
        check_out("midreset", 0, 0, 0, 0, 1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 8'h00);
        tick();
        wcount = 0;
        send(8'hAA); wcount += int'(wr);
        send(8'hBB); wcount += int'(wr);
        send(8'hCC); wcount += int'(wr);
        send(8'hDD);
        check_out("midreset_word", 1, 1, 0, 0, 1, 32'hAABB_CCDD, 32'h0);
        for (int k = 0; k < 4; k++) begin
            idle();
            wcount += int'(wr);
        end
        chk("midreset_extra_writes", wcount, 0);

        // i_start inside RECEIVE changes neither address nor byte count.
        do_reset();
        drive(1'b1, 1'b0, 8'h00);
        tick();
        send(8'h10);
        send(8'h20);
        drive(1'b1, 1'b0, 8'h00);
        tick();
        check_out("start_in_rx", 0, 1, 0, 0, 1, 32'h0, 32'h0);
        send(8'h30);
        send(8'h40);
        check_out("start_in_rx_w0", 1, 1, 0, 0, 1, 32'h1020_3040, 32'h0);
        idle();
        send(8'h50);
        drive(1'b1, 1'b0, 8'h00);
        tick();
        send(8'h60);
        send(8'h70);
        send(8'h80);
        check_out("start_in_rx_w1", 1, 1, 0, 0, 1, 32'h5060_7080, 32'h1);
        idle();
        check_out("start_in_rx_after", 0, 1, 0, 0, 1, 32'h5060_7080, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program loader that fills the instruction memory before execution.
- Takes a byte stream from the UART receiver (one-cycle valid strobes) and packs every 4 bytes into a 32-bit instruction, MSB first.
- Drives the write side of instruction memory: instruction word, word address, load-mode flag, write strobe.
- Stops on the HALT word or when the memory is full, then releases load mode so the fetch stage can start.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- BYTE_WIDTH, 8, width of each incoming byte; DATA_WIDTH/BYTE_WIDTH = 4 bytes per word.
- MEM_DEPTH, 256, number of instruction words; last legal address is MEM_DEPTH-1.
- ADDR_INCR, 1, address step per written word (word-indexed memory).
- HALT_WORD, 32'hFC000000, end-of-program instruction (opcode 6'b111111).

Ports:
- i_clock  input  1  system clock, all logic on the rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_start  input  1  one-cycle pulse that opens a load session.
- i_rx_data  input  BYTE_WIDTH  received byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
- o_instruccion  output  DATA_WIDTH  assembled word presented to memory.
- o_address  output  DATA_WIDTH  word address for o_instruccion.
- o_loading  output  1  high for the whole session; memory in load mode.
- o_write  output  1  one-cycle write strobe.
- o_done  output  1  session finished; held until the next i_start.
- o_overflow  output  1  memory filled before HALT_WORD arrived; held with o_done.

Behaviour:
- Reset: i_reset is synchronous and active-low; one clock with i_reset=0 forces the following, whatever the state:
  - state IDLE;
  - o_instruccion, o_address, o_loading, o_write, o_done, o_overflow all 0;
  - byte count and assembly register 0.
- States: IDLE, RECEIVE, WRITE, DONE.
- IDLE: outputs held at reset values. i_start=1 -> RECEIVE, with address=0 and byte count=0. Bytes arriving in IDLE are ignored.
- RECEIVE:
  - o_loading=1.
  - Each i_rx_valid shifts left: assembly = {assembly[23:0], i_rx_data}, count+1.
  - On the 4th byte (count 3->0): latch the assembly result into o_instruccion, go to WRITE next cycle.
  - Latency: o_write asserts exactly one cycle after the 4th strobe.
  - i_start is ignored in RECEIVE.
- WRITE (exactly one cycle):
  - o_write=1, o_loading=1, o_address = current address.
  - A byte strobed in this cycle is accepted as byte 0 of the next word (count becomes 1); no byte is ever dropped.
  - If o_instruccion == HALT_WORD -> DONE (the HALT word itself is written).
  - Else if address == MEM_DEPTH-1 -> DONE with o_overflow=1.
  - Else address += ADDR_INCR -> RECEIVE.
- DONE:
  - o_loading=0, o_write=0, o_done=1.
  - o_instruccion and o_address keep the last written values.
  - Bytes are ignored.
  - i_start=1 -> RECEIVE: clears o_done and o_overflow, address=0, count=0.
- Address arithmetic is unsigned DATA_WIDTH; it never wraps, because the overflow check fires first.
- Reset mid-session: the partial word is discarded and nothing is written.

Decomposition:
- Shared package:
  - state enum: IDLE, RECEIVE, WRITE, DONE;
  - HALT_WORD constant;
  - BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH.
- One sub-module, word_assembler: shift register plus byte counter with a word_ready pulse; the FSM consumes word_ready.

Test Plan:
- Basic load: reset, i_start, bytes 20 01 00 05 then FC 00 00 00 -> write 32'h20010005 @0, write 32'hFC000000 @1, then o_done=1, o_loading=0, o_overflow=0.
- Latency and strobe: 4th byte strobe at cycle N -> o_write=1 only in cycle N+1, o_loading=1 from i_start+1 until DONE.
- Back-to-back: a byte strobed during the WRITE cycle -> becomes MSB of the next word; next write shows the correct word @1.
- Overflow: MEM_DEPTH=4, stream 4 non-HALT words -> writes @0..@3, then o_done=1, o_overflow=1, no 5th write; further bytes are ignored.
- Reset mid-word: 2 bytes, i_reset=0 for one cycle, then i_start plus 4 bytes AA BB CC DD -> a single write of 32'hAABBCCDD @0.
- Restart: after DONE, i_start -> o_done=0, address restarts at 0; i_start pulsed during RECEIVE -> no effect on address or count.
